lsu_mem: RTL and testbench

LSU_MEM -- requirements
Module: lsu_mem

---
 rtl/lsu_mem.sv | 154 +++++++++++++++
 tb/tb_lsu_mem.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem.sv
// Load/store unit for the MEM stage: issues one data-bus access per memory
// instruction through a three-state FSM and formats load results for writeback.
module lsu_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_mem,
    input  logic        store_mem,
    input  logic [2:0]  funct3_mem,
    input  logic [31:0] alu_data_mem,
    input  logic [31:0] rs2_data_mem,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    input  logic        dbus_ready,
    input  logic [31:0] dbus_rdata,
    output logic [31:0] dm_data_mem,
    output logic        stall,
    output logic        misaligned,
    output logic [1:0]  fsm_state_o
);

    // Bus handshake: the request is held while dbus_req=1 and retires on the
    // first cycle that also has dbus_ready=1; rdata is only sampled then.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] dm_data_q;
    logic        misaligned_q;

    logic        access;
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        misalign_d;
    logic [1:0]  off;
    logic [31:0] wdata_d;
    logic [3:0]  be_d;

    logic        ld_byte;
    logic        ld_half;
    logic        ld_signed;
    logic [31:0] rshift;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] load_fmt_d;

    // Request decode; undefined funct3 codes fall into the word case.
    always_comb begin
        access  = load_mem | store_mem;
        off     = alu_data_mem[1:0];
        is_byte = (funct3_mem == 3'b000) || (funct3_mem == 3'b100);
        is_half = (funct3_mem == 3'b001) || (funct3_mem == 3'b101);
        is_word = !is_byte && !is_half;
        misalign_d = (is_half && off[0]) || (is_word && (off != 2'b00));

        wdata_d = rs2_data_mem;
        be_d    = 4'b1111;
        if (store_mem) begin
            if (is_byte) begin
                wdata_d = {4{rs2_data_mem[7:0]}};
                be_d    = 4'b0001 << off;
            end else if (is_half) begin
                wdata_d = {2{rs2_data_mem[15:0]}};
                be_d    = 4'b0011 << off;
            end
        end
    end

    // Load formatting uses the latched offset and size, not the live inputs.
    always_comb begin
        ld_byte   = (funct3_q == 3'b000) || (funct3_q == 3'b100);
        ld_half   = (funct3_q == 3'b001) || (funct3_q == 3'b101);
        ld_signed = !funct3_q[2];
        rshift    = dbus_rdata >> {addr_q[1:0], 3'b000};
        ld_b      = rshift[7:0];
        ld_h      = addr_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        if (ld_byte) begin
            load_fmt_d = {{24{ld_signed & ld_b[7]}}, ld_b};
        end else if (ld_half) begin
            load_fmt_d = {{16{ld_signed & ld_h[15]}}, ld_h};
        end else begin
            load_fmt_d = dbus_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            we_q         <= 1'b0;
            funct3_q     <= '0;
            dm_data_q    <= '0;
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (access && misalign_d) begin
                        misaligned_q <= 1'b1;
                    end else if (access) begin
                        addr_q   <= alu_data_mem;
                        wdata_q  <= store_mem ? wdata_d : 32'h0;
                        be_q     <= be_d;
                        we_q     <= store_mem;
                        funct3_q <= funct3_mem;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (dbus_ready) begin
                        if (!we_q) begin
                            dm_data_q <= load_fmt_d;
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Bus outputs are gated so nothing leaks onto the bus outside BUSY.
    always_comb begin
        dbus_req   = (state_q == BUSY);
        dbus_we    = dbus_req ? we_q : 1'b0;
        dbus_addr  = dbus_req ? {addr_q[31:2], 2'b00} : 32'h0;
        dbus_wdata = dbus_req ? wdata_q : 32'h0;
        dbus_be    = dbus_req ? be_q : 4'b0000;
        stall      = ((state_q == IDLE) && access && !misalign_d) || (state_q == BUSY);
    end

    assign dm_data_mem = dm_data_q;
    assign misaligned  = misaligned_q;
    assign fsm_state_o = state_q;

endmodule

// File: tb/tb_lsu_mem.sv
// Directed bench for lsu_mem: load formatting, store lanes, bus wait states,
// misaligned rejection and reset while an access is outstanding.
module tb_lsu_mem;

    logic        clk;
    logic        rst;
    logic        load_mem;
    logic        store_mem;
    logic [2:0]  funct3_mem;
    logic [31:0] alu_data_mem;
    logic [31:0] rs2_data_mem;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_be;
    logic        dbus_ready;
    logic [31:0] dbus_rdata;
    logic [31:0] dm_data_mem;
    logic        stall;
    logic        misaligned;
    logic [1:0]  fsm_state_o;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [31:0] exp_dm;

    lsu_mem dut (
        .clk          (clk),
        .rst          (rst),
        .load_mem     (load_mem),
        .store_mem    (store_mem),
        .funct3_mem   (funct3_mem),
        .alu_data_mem (alu_data_mem),
        .rs2_data_mem (rs2_data_mem),
        .dbus_req     (dbus_req),
        .dbus_we      (dbus_we),
        .dbus_addr    (dbus_addr),
        .dbus_wdata   (dbus_wdata),
        .dbus_be      (dbus_be),
        .dbus_ready   (dbus_ready),
        .dbus_rdata   (dbus_rdata),
        .dm_data_mem  (dm_data_mem),
        .stall        (stall),
        .misaligned   (misaligned),
        .fsm_state_o  (fsm_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        load_mem     = 1'b0;
        store_mem    = 1'b0;
        funct3_mem   = 3'b000;
        alu_data_mem = 32'h0;
        rs2_data_mem = 32'h0;
        dbus_ready   = 1'b0;
        dbus_rdata   = 32'h0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        #1;
        vec_cnt++;
        if (fsm_state_o !== 2'd0 || stall !== 1'b0 || dbus_req !== 1'b0 || dm_data_mem !== 32'h0
            || misaligned !== 1'b0 || dbus_addr !== 32'h0 || dbus_be !== 4'h0) begin
            err_cnt++;
            $display("FAIL reset: state=%0d stall=%b req=%b dm=%h mis=%b addr=%h be=%b, required 0/0/0/0/0/0/0",
                     fsm_state_o, stall, dbus_req, dm_data_mem, misaligned, dbus_addr, dbus_be);
        end
        exp_dm = 32'h0;
    endtask

    task automatic test_lw;
        int stall_cycles;
        stall_cycles = 0;
        load_mem = 1'b1; funct3_mem = 3'b010; alu_data_mem = 32'h100;
        #1;
        vec_cnt++;
        if (stall !== 1'b1 || dbus_req !== 1'b0) begin
            err_cnt++;
            $display("FAIL lw_idle: stall=%b req=%b, required 1/0", stall, dbus_req);
        end
        stall_cycles += stall;
        tick();
        dbus_ready = 1'b1; dbus_rdata = 32'hDEADBEEF;
        #1;
        vec_cnt++;
        if (dbus_req !== 1'b1 || dbus_we !== 1'b0 || dbus_addr !== 32'h100 || dbus_be !== 4'b1111
            || stall !== 1'b1 || fsm_state_o !== 2'd1) begin
            err_cnt++;
            $display("FAIL lw_busy: req=%b we=%b addr=%h be=%b stall=%b state=%0d, required 1/0/00000100/1111/1/1",
                     dbus_req, dbus_we, dbus_addr, dbus_be, stall, fsm_state_o);
        end
        stall_cycles += stall;
        tick();
        dbus_ready = 1'b0; dbus_rdata = 32'h0;
        #1;
        exp_dm = 32'hDEADBEEF;
        vec_cnt++;
        if (stall !== 1'b0 || dbus_req !== 1'b0 || dm_data_mem !== exp_dm || fsm_state_o !== 2'd2
            || stall_cycles != 2) begin
            err_cnt++;
            $display("FAIL lw_done: stall=%b req=%b dm=%h state=%0d stall_cycles=%0d, required 0/0/%h/2/2",
                     stall, dbus_req, dm_data_mem, fsm_state_o, stall_cycles, exp_dm);
        end
        idle_inputs();
        tick();
        vec_cnt++;
        if (fsm_state_o !== 2'd0 || dm_data_mem !== exp_dm) begin
            err_cnt++;
            $display("FAIL lw_return: state=%0d dm=%h, required 0/%h", fsm_state_o, dm_data_mem, exp_dm);
        end
    endtask

    task automatic test_load_format;
        logic [2:0]  f3_t[9]   = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000,
                                   3'b101, 3'b011, 3'b100, 3'b111};
        logic [31:0] addr_t[9] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100,
                                   32'h100, 32'h104, 32'h101, 32'h108};
        logic [31:0] rd_t[9]   = '{32'h80FFFFFF, 32'h80FFFFFF, 32'h80011234, 32'h80011234, 32'h1234567F,
                                   32'hABCDFFFE, 32'hCAFEF00D, 32'h0000A500, 32'h89ABCDEF};
        logic [31:0] exp_t[9]  = '{32'hFFFFFF80, 32'h00000080, 32'h00008001, 32'hFFFF8001, 32'h0000007F,
                                   32'h0000FFFE, 32'hCAFEF00D, 32'h000000A5, 32'h89ABCDEF};
        for (int i = 0; i < 9; i++) begin
            load_mem = 1'b1; funct3_mem = f3_t[i]; alu_data_mem = addr_t[i];
            tick();
            dbus_ready = 1'b1; dbus_rdata = rd_t[i];
            #1;
            vec_cnt++;
            if (dbus_req !== 1'b1 || dbus_addr !== {addr_t[i][31:2], 2'b00} || dbus_be !== 4'b1111
                || dbus_we !== 1'b0) begin
                err_cnt++;
                $display("FAIL load_bus[%0d]: req=%b addr=%h be=%b we=%b, required 1/%h/1111/0",
                         i, dbus_req, dbus_addr, dbus_be, dbus_we, {addr_t[i][31:2], 2'b00});
            end
            tick();
            idle_inputs();
            #1;
            exp_dm = exp_t[i];
            vec_cnt++;
            if (dm_data_mem !== exp_dm) begin
                err_cnt++;
                $display("FAIL load_fmt[%0d]: dm=%h, required %h", i, dm_data_mem, exp_dm);
            end
            tick();
        end
    endtask

    task automatic test_store;
        logic [2:0]  f3_t[4]   = '{3'b000, 3'b001, 3'b000, 3'b010};
        logic [31:0] addr_t[4] = '{32'h201, 32'h202, 32'h203, 32'h204};
        logic [31:0] rs2_t[4]  = '{32'h000000AB, 32'h00001234, 32'h55667788, 32'hA5A55A5A};
        logic [31:0] wd_t[4]   = '{32'hABABABAB, 32'h12341234, 32'h88888888, 32'hA5A55A5A};
        logic [3:0]  be_t[4]   = '{4'b0010, 4'b1100, 4'b1000, 4'b1111};
        logic [31:0] ad_t[4]   = '{32'h200, 32'h200, 32'h200, 32'h204};
        for (int i = 0; i < 4; i++) begin
            store_mem = 1'b1; funct3_mem = f3_t[i]; alu_data_mem = addr_t[i]; rs2_data_mem = rs2_t[i];
            tick();
            dbus_ready = 1'b1; dbus_rdata = 32'hFFFFFFFF;
            #1;
            vec_cnt++;
            if (dbus_req !== 1'b1 || dbus_we !== 1'b1 || dbus_addr !== ad_t[i] || dbus_be !== be_t[i]
                || dbus_wdata !== wd_t[i]) begin
                err_cnt++;
                $display("FAIL store_bus[%0d]: req=%b we=%b addr=%h be=%b wdata=%h, required 1/1/%h/%b/%h",
                         i, dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, ad_t[i], be_t[i], wd_t[i]);
            end
            tick();
            idle_inputs();
            #1;
            vec_cnt++;
            if (dm_data_mem !== exp_dm || stall !== 1'b0 || dbus_wdata !== 32'h0) begin
                err_cnt++;
                $display("FAIL store_done[%0d]: dm=%h stall=%b wdata=%h, required %h/0/00000000",
                         i, dm_data_mem, stall, dbus_wdata, exp_dm);
            end
            tick();
        end
    endtask

    task automatic test_wait_states;
        int stall_cycles;
        stall_cycles = 0;
        store_mem = 1'b1; funct3_mem = 3'b010; alu_data_mem = 32'h300; rs2_data_mem = 32'h11223344;
        tick();
        for (int c = 0; c < 5; c++) begin
            dbus_ready = (c == 4);
            #1;
            vec_cnt++;
            if (dbus_req !== 1'b1 || dbus_addr !== 32'h300 || dbus_wdata !== 32'h11223344
                || dbus_be !== 4'b1111 || dbus_we !== 1'b1 || stall !== 1'b1) begin
                err_cnt++;
                $display("FAIL wait_busy[%0d]: req=%b addr=%h wdata=%h be=%b we=%b stall=%b, required 1/300/11223344/1111/1/1",
                         c, dbus_req, dbus_addr, dbus_wdata, dbus_be, dbus_we, stall);
            end
            stall_cycles += stall;
            tick();
        end
        idle_inputs();
        #1;
        vec_cnt++;
        if (fsm_state_o !== 2'd2 || stall !== 1'b0 || dbus_req !== 1'b0 || stall_cycles != 5
            || dm_data_mem !== exp_dm) begin
            err_cnt++;
            $display("FAIL wait_done: state=%0d stall=%b req=%b stall_cycles=%0d dm=%h, required 2/0/0/5/%h",
                     fsm_state_o, stall, dbus_req, stall_cycles, dm_data_mem, exp_dm);
        end
        tick();
    endtask

    task automatic test_misaligned;
        logic       ld_t[4]    = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [2:0] f3_t[4]    = '{3'b001, 3'b010, 3'b010, 3'b101};
        logic [31:0] addr_t[4] = '{32'h101, 32'h102, 32'h301, 32'h103};
        for (int i = 0; i < 4; i++) begin
            load_mem = ld_t[i]; store_mem = !ld_t[i]; funct3_mem = f3_t[i]; alu_data_mem = addr_t[i];
            #1;
            vec_cnt++;
            if (stall !== 1'b0 || dbus_req !== 1'b0) begin
                err_cnt++;
                $display("FAIL misalign_req[%0d]: stall=%b req=%b, required 0/0", i, stall, dbus_req);
            end
            tick();
            idle_inputs();
            #1;
            vec_cnt++;
            if (misaligned !== 1'b1 || dbus_req !== 1'b0 || fsm_state_o !== 2'd0) begin
                err_cnt++;
                $display("FAIL misalign_pulse[%0d]: mis=%b req=%b state=%0d, required 1/0/0",
                         i, misaligned, dbus_req, fsm_state_o);
            end
            tick();
            vec_cnt++;
            if (misaligned !== 1'b0 || dm_data_mem !== exp_dm) begin
                err_cnt++;
                $display("FAIL misalign_end[%0d]: mis=%b dm=%h, required 0/%h", i, misaligned, dm_data_mem, exp_dm);
            end
        end
    endtask

    task automatic test_reset_busy;
        load_mem = 1'b1; funct3_mem = 3'b010; alu_data_mem = 32'h400;
        tick();
        rst = 1'b1;
        #1;
        vec_cnt++;
        if (dbus_req !== 1'b1 || fsm_state_o !== 2'd1) begin
            err_cnt++;
            $display("FAIL rst_busy_pre: req=%b state=%0d, required 1/1", dbus_req, fsm_state_o);
        end
        tick();
        rst = 1'b0;
        idle_inputs();
        dbus_ready = 1'b1; dbus_rdata = 32'h12345678;
        #1;
        exp_dm = 32'h0;
        vec_cnt++;
        if (dbus_req !== 1'b0 || fsm_state_o !== 2'd0 || dm_data_mem !== exp_dm || stall !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_busy_after: req=%b state=%0d dm=%h stall=%b, required 0/0/%h/0",
                     dbus_req, fsm_state_o, dm_data_mem, stall, exp_dm);
        end
        tick();
        dbus_ready = 1'b0;
        #1;
        vec_cnt++;
        if (dm_data_mem !== exp_dm || fsm_state_o !== 2'd0 || dbus_req !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_busy_late_ready: dm=%h state=%0d req=%b, required %h/0/0",
                     dm_data_mem, fsm_state_o, dbus_req, exp_dm);
        end
    endtask

    initial begin
        exp_dm = 32'h0;
        test_reset();
        test_lw();
        test_load_format();
        test_store();
        test_wait_states();
        test_misaligned();
        test_reset_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
